// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit.
// Runs one operation at a time, with valid/ready handshakes on input and output.
// A flush cancels any operation in flight and drops a pending result.
module mdu #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_src1,
    input  logic [WIDTH-1:0] in_src2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result
);

    // One counter serves both paths. It is sized for WIDTH divide steps.
    // MUL_STAGES is assumed to be no larger than WIDTH.
    localparam int unsigned   CW      = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] MulLast = CW'(MUL_STAGES - 1);
    localparam logic [CW-1:0] DivLast = CW'(WIDTH);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e           state_q, state_d;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] src1_q, src2_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] quo_q;     // dividend shifts out, quotient bits shift in
    logic [WIDTH-1:0] rem_q;     // partial remainder magnitude
    logic [WIDTH-1:0] result_q;
    logic             valid_q;

    logic             accept;
    logic             in_signed;
    logic [WIDTH-1:0] in_dvd_mag;

    logic               mul_sext;
    logic [2*WIDTH-1:0] mul_a, mul_b, mul_prod;
    logic [WIDTH-1:0]   mul_res;

    logic             div_signed, sign1, sign2, div_zero;
    logic [WIDTH-1:0] dvs_mag, quo_fix, rem_fix, div_res;
    logic [WIDTH:0]   div_shift, div_diff;

    assign accept = in_valid & in_ready & ~flush;

    // Dividend magnitude is taken from the incoming operands so the first step can start at once.
    always_comb begin
        in_signed  = ~in_op[1];
        in_dvd_mag = (in_signed & in_src1[WIDTH-1]) ? -in_src1 : in_src1;
    end

    // Multiplier: a 2*WIDTH-bit product of extended operands holds every result bit that is needed.
    always_comb begin
        mul_sext = (op_q[1:0] != 2'b10);
        mul_a    = {{WIDTH{mul_sext & src1_q[WIDTH-1]}}, src1_q};
        mul_b    = {{WIDTH{mul_sext & src2_q[WIDTH-1]}}, src2_q};
        mul_prod = mul_a * mul_b;
        mul_res  = (op_q[1:0] == 2'b01 || op_q[1:0] == 2'b10) ? mul_prod[2*WIDTH-1:WIDTH]
                                                              : mul_prod[WIDTH-1:0];
    end

    // One restoring step, plus the sign fixup that builds the final quotient or remainder.
    always_comb begin
        div_signed = ~op_q[1];
        sign1      = div_signed & src1_q[WIDTH-1];
        sign2      = div_signed & src2_q[WIDTH-1];
        div_zero   = (src2_q == '0);
        dvs_mag    = sign2 ? -src2_q : src2_q;
        div_shift  = {rem_q, quo_q[WIDTH-1]};
        div_diff   = div_shift - {1'b0, dvs_mag};
        quo_fix    = div_zero ? '1 : ((sign1 ^ sign2) ? -quo_q : quo_q);
        rem_fix    = div_zero ? src1_q : (sign1 ? -rem_q : rem_q);
        div_res    = op_q[0] ? rem_fix : quo_fix;
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Flush has priority over every other transition.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = in_op[2] ? StDiv : StMul;
                end
            end
            StMul: begin
                if (flush) begin
                    state_d = StIdle;
                end else if (cnt_q == MulLast) begin
                    state_d = StDone;
                end
            end
            StDiv: begin
                if (flush) begin
                    state_d = StIdle;
                end else if (cnt_q == DivLast) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (flush || out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs. in_ready depends only on the state; the result side comes from registers.
    always_comb begin
        in_ready   = (state_q == StIdle);
        out_valid  = valid_q;
        out_result = result_q;
    end

    // Datapath: latch operands, count cycles, step the divider and capture the result.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_q     <= '0;
            src1_q   <= '0;
            src2_q   <= '0;
            cnt_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= (state_d == StDone);
            if (accept) begin
                op_q   <= in_op;
                src1_q <= in_src1;
                src2_q <= in_src2;
                cnt_q  <= '0;
                quo_q  <= in_dvd_mag;
                rem_q  <= '0;
            end else if (state_q == StMul && cnt_q != MulLast) begin
                cnt_q <= cnt_q + CW'(1);
            end else if (state_q == StDiv && cnt_q != DivLast) begin
                cnt_q <= cnt_q + CW'(1);
                if (div_diff[WIDTH]) begin
                    rem_q <= div_shift[WIDTH-1:0];
                    quo_q <= {quo_q[WIDTH-2:0], 1'b0};
                end else begin
                    rem_q <= div_diff[WIDTH-1:0];
                    quo_q <= {quo_q[WIDTH-2:0], 1'b1};
                end
            end
            // Capture only when entering DONE, so the result holds while it waits.
            if (state_q != StDone && state_d == StDone) begin
                result_q <= (state_q == StMul) ? mul_res : div_res;
            end
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu (WIDTH=32, MUL_STAGES=2).
// A transaction-level model predicts in_ready, out_valid and out_result on every cycle.
module tb_mdu;
    localparam int unsigned W  = 32;
    localparam int unsigned MS = 2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = '0;
    logic [31:0] in_src1 = '0;
    logic [31:0] in_src2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;

    int n_tests = 0;
    int n_fail  = 0;

    mdu #(.WIDTH(W), .MUL_STAGES(MS)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_src1(in_src1), .in_src2(in_src2),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30) $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural result of one operation, from plain integer arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] p;
        int sa, sb;
        sa = a;
        sb = b;
        p  = '0;
        case (op)
            3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
            3'd2: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return '1;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return sa / sb;
            end
            3'd5: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return '0;
                return sa % sb;
            end
            3'd6: begin if (b == 0) return '1; return a / b; end
            3'd7: begin if (b == 0) return a; return a % b; end
            default: return a * b;
        endcase
    endfunction

    // The model holds one op at a time and counts down its latency.
    logic        m_busy = 1'b0;
    logic        m_valid = 1'b0;
    int          m_rem = 0;
    logic [31:0] m_exp = '0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_rem   <= 0;
        end else if (flush) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
        end else if (m_valid) begin
            if (out_ready) begin
                m_busy  <= 1'b0;
                m_valid <= 1'b0;
            end
        end else if (m_busy) begin
            if (m_rem == 1) m_valid <= 1'b1;
            m_rem <= m_rem - 1;
        end else if (in_valid) begin
            m_busy <= 1'b1;
            m_rem  <= in_op[2] ? int'(W) + 1 : int'(MS);
            m_exp  <= ref_result(in_op, in_src1, in_src2);
        end
    end

    // Compare the DUT against the model on every falling edge.
    always @(negedge clk) begin
        chk("in_ready", {31'b0, in_ready}, {31'b0, ~m_busy});
        chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
        if (m_valid) chk("out_result", out_result, m_exp);
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int g;
        g = 0;
        while (!in_ready && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        chk("issue in_ready timeout", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_op    = op;
        in_src1  = a;
        in_src2  = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run_lit(input string name, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        int n;
        chk({name, " model"}, ref_result(op, a, b), exp);
        issue(op, a, b);
        wait_valid(n);
        chk({name, " latency"}, 32'(n), op[2] ? 32'(W + 1) : 32'(MS));
        chk({name, " result"}, out_result, exp);
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int          n;
        logic [31:0] held;
        logic        seen;

        // Reset is taken at the first edge and held through it.
        @(posedge clk); #1;
        chk("reset in_ready", {31'b0, in_ready}, 32'd1);
        chk("reset out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset out_result", out_result, 32'd0);
        resetn = 1'b1;
        @(posedge clk); #1;

        run_lit("mul 0x10000^2", 3'd0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000);
        run_lit("mulh 0x10000^2", 3'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001);
        run_lit("mul -1*-1", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        run_lit("mulh -1*-1", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
        run_lit("mulhu max^2", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_lit("op3 as mul", 3'd3, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE);
        run_lit("div -7/2", 3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD);
        run_lit("mod -7/2", 3'd5, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF);
        run_lit("divu 7/2", 3'd6, 32'd7, 32'd2, 32'd3);
        run_lit("modu 7/2", 3'd7, 32'd7, 32'd2, 32'd1);
        run_lit("div 5/0", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF);
        run_lit("mod 5/0", 3'd5, 32'd5, 32'd0, 32'd5);
        run_lit("div -5/0", 3'd4, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF);
        run_lit("divu min/0", 3'd6, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF);
        run_lit("modu 7/0", 3'd7, 32'd7, 32'd0, 32'd7);
        run_lit("div ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_lit("mod ovf", 3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);

        // Backpressure: the result holds and a new request waits.
        out_ready = 1'b0;
        issue(3'd0, 32'd6, 32'd7);
        wait_valid(n);
        chk("bp latency", 32'(n), 32'(MS));
        held = out_result;
        chk("bp result", held, 32'd42);
        in_valid = 1'b1;
        in_op    = 3'd0;
        in_src1  = 32'd3;
        in_src2  = 32'd4;
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp stable", out_result, held);
            chk("bp in_ready low", {31'b0, in_ready}, 32'd0);
            chk("bp out_valid held", {31'b0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp handshake out_valid", {31'b0, out_valid}, 32'd0);
        chk("bp handshake in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp next accept", {31'b0, in_ready}, 32'd0);
        wait_valid(n);
        chk("bp next latency", 32'(n), 32'(MS));
        chk("bp next result", out_result, 32'd12);
        @(posedge clk); #1;

        // Flush in the middle of a divide.
        issue(3'd4, 32'd100, 32'd7);
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush in_ready", {31'b0, in_ready}, 32'd1);
        chk("flush out_valid", {31'b0, out_valid}, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("flush no result", {31'b0, seen}, 32'd0);
        run_lit("mul 3x4 after flush", 3'd0, 32'd3, 32'd4, 32'd12);

        // A flush in the same cycle as in_valid blocks the accept.
        in_valid = 1'b1;
        flush    = 1'b1;
        in_op    = 3'd0;
        in_src1  = 32'd5;
        in_src2  = 32'd5;
        @(posedge clk); #1;
        chk("flush+valid no accept", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b0;
        flush    = 1'b0;
        @(posedge clk); #1;

        // An asynchronous reset in the middle of a multiply.
        issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
        #1 resetn = 1'b0;
        #1;
        chk("async rst in_ready", {31'b0, in_ready}, 32'd1);
        chk("async rst out_valid", {31'b0, out_valid}, 32'd0);
        chk("async rst out_result", out_result, 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;

        // Random traffic, backpressure and flushes, all checked by the compare process.
        for (int c = 0; c < 6000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_op     = 3'($urandom_range(0, 7));
            in_src1   = pick();
            in_src2   = pick();
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 99) == 0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (50) begin @(posedge clk); #1; end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
